// File: rtl/saturate_stage_pkg.sv
// Shared widths and clamp classification for the saturate stage.
// PIXEL_W is the pixel channel width used as the default output width.
package saturate_stage_pkg;

    localparam int PIXEL_W   = 8;
    localparam int SAMPLE_W  = 10;
    localparam int SAT_CNT_W = 16;

    typedef enum logic [1:0] {
        SAT_NONE = 2'b00,
        SAT_LO   = 2'b01,
        SAT_HI   = 2'b10
    } sat_kind_e;

endpackage

// File: rtl/saturate_stage_if.sv
// Sample/result bundle between a pixel datapath and the saturate stage.
// The master drives samples and counter clears; the slave returns clamp results.
interface saturate_stage_if
    import saturate_stage_pkg::*;
#(
    parameter int IN_W  = SAMPLE_W,
    parameter int OUT_W = PIXEL_W,
    parameter int CNT_W = SAT_CNT_W
);

    logic                    in_valid;
    logic signed [IN_W-1:0]  in_data;
    logic                    cnt_clr;
    logic [OUT_W-1:0]        sat_comb;
    logic                    out_valid;
    logic [OUT_W-1:0]        out_data;
    logic                    out_hi;
    logic                    out_lo;
    logic [CNT_W-1:0]        hi_cnt;
    logic [CNT_W-1:0]        lo_cnt;

    modport master (
        output in_valid, in_data, cnt_clr,
        input  sat_comb, out_valid, out_data, out_hi, out_lo, hi_cnt, lo_cnt
    );

    modport slave (
        input  in_valid, in_data, cnt_clr,
        output sat_comb, out_valid, out_data, out_hi, out_lo, hi_cnt, lo_cnt
    );

endinterface

// File: rtl/saturate_stage.sv
// Clamps a signed intermediate into an unsigned pixel channel, with a
// combinational result, a registered copy and sticky saturation counters.
module saturate_stage
    import saturate_stage_pkg::*;
#(
    parameter int IN_W  = SAMPLE_W,
    parameter int OUT_W = PIXEL_W,
    parameter int CNT_W = SAT_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    saturate_stage_if.slave bus
);

    // Sign bit set means below zero; any set bit above the output width on a
    // non-negative sample means above MAX.
    function automatic logic [OUT_W-1:0] clamp(input logic [IN_W-1:0] x,
                                               output sat_kind_e kind);
        if (x[IN_W-1]) begin
            kind = SAT_LO;
            return '0;
        end else if (|x[IN_W-2:OUT_W]) begin
            kind = SAT_HI;
            return '1;
        end else begin
            kind = SAT_NONE;
            return x[OUT_W-1:0];
        end
    endfunction

    logic [OUT_W-1:0] clamp_data;
    sat_kind_e        clamp_kind;
    logic             is_hi;
    logic             is_lo;

    always_comb begin
        clamp_kind = SAT_NONE;
        clamp_data = clamp(bus.in_data, clamp_kind);
    end

    assign is_hi        = (clamp_kind == SAT_HI);
    assign is_lo        = (clamp_kind == SAT_LO);
    assign bus.sat_comb = clamp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_hi    <= 1'b0;
            bus.out_lo    <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.out_data <= clamp_data;
                bus.out_hi   <= is_hi;
                bus.out_lo   <= is_lo;
            end
        end
    end

    // A clear drops any coincident event; counters hold at all-ones.
    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr) begin
            bus.hi_cnt <= '0;
            bus.lo_cnt <= '0;
        end else if (bus.in_valid) begin
            if (is_hi && (bus.hi_cnt != '1))
                bus.hi_cnt <= bus.hi_cnt + 1'b1;
            if (is_lo && (bus.lo_cnt != '1))
                bus.lo_cnt <= bus.lo_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_saturate_stage.sv
// Scoreboard bench for saturate_stage: a wide-counter instance and a 2-bit
// counter instance see identical stimulus and are checked against a model.
module tb_saturate_stage;

    localparam int IN_W  = 10;
    localparam int OUT_W = 8;
    localparam int MAXV  = 255;
    localparam int CAP_W = 65535;
    localparam int CAP_S = 3;

    typedef struct {
        int data;
        int hi;
        int lo;
    } exp_t;

    logic clk;
    logic rst;

    saturate_stage_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(16)) bus_w ();
    saturate_stage_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(2))  bus_s ();

    saturate_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    saturate_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(2)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    int   m_hi, m_lo, m_hi_s, m_lo_s;
    int   last_data, last_hi, last_lo;

    task automatic check_output(input string tag, input logic [31:0] got,
                                input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_clamp(input int v);
        exp_t e;
        if (v < 0) begin
            e.data = 0;    e.hi = 0; e.lo = 1;
        end else if (v > MAXV) begin
            e.data = MAXV; e.hi = 1; e.lo = 0;
        end else begin
            e.data = v;    e.hi = 0; e.lo = 0;
        end
        return e;
    endfunction

    function automatic int sat_inc(input int c, input int cap);
        return (c >= cap) ? cap : c + 1;
    endfunction

    task automatic check_counters(input string tag);
        check_output({tag, ".hi_cnt"},   32'(bus_w.hi_cnt), m_hi);
        check_output({tag, ".lo_cnt"},   32'(bus_w.lo_cnt), m_lo);
        check_output({tag, ".hi_cnt_s"}, 32'(bus_s.hi_cnt), m_hi_s);
        check_output({tag, ".lo_cnt_s"}, 32'(bus_s.lo_cnt), m_lo_s);
    endtask

    // Drive one cycle, check the combinational clamp, then the registered result.
    task automatic apply_stimulus(input logic v, input int d, input logic clr);
        logic [IN_W-1:0] dv;
        exp_t e, got_e;
        dv = d[IN_W-1:0];
        bus_w.in_valid = v; bus_w.in_data = dv; bus_w.cnt_clr = clr;
        bus_s.in_valid = v; bus_s.in_data = dv; bus_s.cnt_clr = clr;
        e = model_clamp(d);
        #1;
        check_output("sat_comb", 32'(bus_w.sat_comb), e.data);
        if (v) sb.push_back(e);
        if (clr) begin
            m_hi = 0; m_lo = 0; m_hi_s = 0; m_lo_s = 0;
        end else if (v) begin
            if (e.hi != 0) begin
                m_hi = sat_inc(m_hi, CAP_W); m_hi_s = sat_inc(m_hi_s, CAP_S);
            end
            if (e.lo != 0) begin
                m_lo = sat_inc(m_lo, CAP_W); m_lo_s = sat_inc(m_lo_s, CAP_S);
            end
        end
        @(posedge clk);
        #1;
        if (v) begin
            check_output("out_valid", 32'(bus_w.out_valid), 1);
            if (sb.size() == 0) begin
                check_output("scoreboard_empty", 0, 1);
            end else begin
                got_e = sb.pop_front();
                last_data = got_e.data; last_hi = got_e.hi; last_lo = got_e.lo;
            end
        end else begin
            check_output("out_valid_idle", 32'(bus_w.out_valid), 0);
        end
        check_output("out_data", 32'(bus_w.out_data), last_data);
        check_output("out_hi",   32'(bus_w.out_hi),   last_hi);
        check_output("out_lo",   32'(bus_w.out_lo),   last_lo);
        check_counters("step");
    endtask

    // Reset with a coincident valid sample, which must be discarded.
    task automatic apply_reset();
        rst = 1'b1;
        bus_w.in_valid = 1'b1; bus_w.in_data = 10'sd300; bus_w.cnt_clr = 1'b0;
        bus_s.in_valid = 1'b1; bus_s.in_data = 10'sd300; bus_s.cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_w.in_valid = 1'b0; bus_s.in_valid = 1'b0;
        sb.delete();
        m_hi = 0; m_lo = 0; m_hi_s = 0; m_lo_s = 0;
        last_data = 0; last_hi = 0; last_lo = 0;
        check_output("rst.out_valid", 32'(bus_w.out_valid), 0);
        check_output("rst.out_data",  32'(bus_w.out_data),  0);
        check_output("rst.out_hi",    32'(bus_w.out_hi),    0);
        check_output("rst.out_lo",    32'(bus_w.out_lo),    0);
        check_counters("rst");
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus_w.in_valid = 1'b0; bus_w.in_data = '0; bus_w.cnt_clr = 1'b0;
        bus_s.in_valid = 1'b0; bus_s.in_data = '0; bus_s.cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        apply_reset();

        $display("[TB] sweep -512..511");
        for (int i = -512; i <= 511; i++) apply_stimulus(1'b1, i, 1'b0);

        $display("[TB] explicit boundaries");
        apply_stimulus(1'b1, 255, 1'b0);
        apply_stimulus(1'b1, 256, 1'b0);
        apply_stimulus(1'b1, -1, 1'b0);
        apply_stimulus(1'b1, 0, 1'b0);
        apply_stimulus(1'b1, 200, 1'b0);

        $display("[TB] reset mid-stream after 300");
        apply_stimulus(1'b1, 300, 1'b0);
        apply_reset();
        apply_stimulus(1'b0, 17, 1'b0);
        apply_stimulus(1'b0, -3, 1'b0);

        $display("[TB] idle sample holds registered outputs");
        apply_stimulus(1'b1, 100, 1'b0);
        apply_stimulus(1'b0, 400, 1'b0);
        check_output("idle.out_data_hold", 32'(bus_w.out_data), 100);

        $display("[TB] 5 high then 3 low");
        apply_stimulus(1'b0, 0, 1'b1);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 300, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, -7, 1'b0);
        check_output("burst.hi_cnt", 32'(bus_w.hi_cnt), 5);
        check_output("burst.lo_cnt", 32'(bus_w.lo_cnt), 3);
        check_output("burst.hi_cnt_small_stuck", 32'(bus_s.hi_cnt), 3);

        $display("[TB] clear beats coincident increment");
        apply_stimulus(1'b1, 300, 1'b1);
        check_output("clr.hi_cnt",   32'(bus_w.hi_cnt),   0);
        check_output("clr.out_data", 32'(bus_w.out_data), 255);
        check_output("clr.out_hi",   32'(bus_w.out_hi),   1);

        $display("[TB] 2-bit counter sticks at 3");
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 511, 1'b0);
        check_output("small.hi_cnt", 32'(bus_s.hi_cnt), 3);
        check_output("wide.hi_cnt",  32'(bus_w.hi_cnt), 6);

        $display("[TB] random samples");
        for (int i = 0; i < 64; i++)
            apply_stimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)) - 512,
                           1'($urandom_range(0, 15) == 0));

        if (sb.size() != 0) check_output("scoreboard_leftover", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/saturate_stage.md
# saturate_stage

Clamping stage that converts a signed fixed-width intermediate (typically a scaled luminance or colour-math result) into an unsigned 8-bit pixel channel. It sits between the arithmetic datapath of a pixel filter (e.g. grayscale luminance) and the channel output mux. It provides a zero-latency combinational clamp for in-line use, a one-cycle registered copy with valid, and per-sample and accumulated saturation statistics.

## Interface
Parameters:
- IN_W, 10: input width, two's complement.
- OUT_W, 8: output width, unsigned; must satisfy OUT_W < IN_W.
- CNT_W, 16: width of each saturation event counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies in_data for the registered path and the counters.
- in_data  in  IN_W  signed sample.
- cnt_clr  in  1  synchronous clear of both counters.
- sat_comb  out  OUT_W  combinational clamp of in_data, independent of in_valid.
- out_valid  out  1  registered in_valid.
- out_data  out  OUT_W  registered clamp result.
- out_hi  out  1  registered: sample clamped to max.
- out_lo  out  1  registered: sample clamped to 0.
- hi_cnt  out  CNT_W  count of valid samples clamped high.
- lo_cnt  out  CNT_W  count of valid samples clamped low.

## Operation
- MAX = 2^OUT_W − 1 (255 by default).
- Input interpreted as signed IN_W bits; range −2^(IN_W−1) to 2^(IN_W−1) − 1.
- Clamp rule: in_data < 0 → 0 with lo = 1; in_data > MAX → MAX with hi = 1; otherwise in_data[OUT_W−1:0], hi = lo = 0.
- hi and lo are never both 1.
- Boundaries: 0 → 0; MAX → MAX, no flag; MAX+1 → MAX, hi; −1 → 0, lo; most-negative → 0, lo; most-positive → MAX, hi.
- sat_comb is purely combinational from in_data, with no dependence on clk, rst or in_valid.
- Counters:
  - On a clock with in_valid = 1, hi_cnt increments if the sample is clamped high, and lo_cnt increments if it is clamped low.
  - Counters stick at 2^CNT_W − 1; they do not wrap.
- cnt_clr priority:
  - rst has highest priority.
  - cnt_clr beats an increment in the same cycle: the result is 0, and the coincident event is dropped.

## Timing
- sat_comb: zero latency.
- out_valid, out_data, out_hi, out_lo: registered, one cycle after the sampling edge.
- The output registers load only when in_valid = 1.
- When in_valid = 0, out_valid falls to 0 and out_data, out_hi and out_lo hold their previous values.
- Reset (synchronous, evaluated on the rising edge of clk): out_valid = 0, out_data = 0, out_hi = 0, out_lo = 0, hi_cnt = 0, lo_cnt = 0.
- If rst and in_valid are both asserted, reset wins and the sample is discarded.
- No backpressure: the block accepts one sample per cycle unconditionally.

## Structure
- One module, saturate_stage, with no sub-modules.
- The clamp is a single combinational function, reused by both sat_comb and the register path.
- No shared package is required. If a pixel package exists, OUT_W defaults there as the pixel channel width (8).

## Test plan
- Sweep in_data over −512..511 (IN_W = 10) with in_valid = 1 → sat_comb and, one cycle later, out_data match the clamp rule:
  - −512 → 0, lo;
  - −1 → 0, lo;
  - 0 → 0;
  - 200 → 200;
  - 255 → 255, no flag;
  - 256 → 255, hi;
  - 511 → 255, hi.
- Reset mid-stream after the sample 300 → all registered outputs and both counters read 0 on the next cycle, and out_valid stays 0 until the next valid sample.
- Apply in_valid = 0 with in_data = 400 → sat_comb = 255 immediately, out_valid = 0, out_data holds its previous value, hi_cnt unchanged.
- Send 5 samples of 300, then 3 samples of −7, all valid → hi_cnt = 5, lo_cnt = 3.
- Assert cnt_clr in the same cycle as a valid 300 sample → hi_cnt = 0 afterwards, while out_data = 255 and out_hi = 1.
- With CNT_W = 2, send 6 high-saturating samples → hi_cnt = 3 (sticks at maximum, does not wrap).
